pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: keeps the PC, issues one instruction-memory
// request at a time, parks a response in a one-entry skid buffer while the
// IF/ID register is stalled, and steers to a new target on a redirect.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        takebranch,
  input  logic [31:0] JalAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   pc;
  logic [DATA_W-1:0]   pc_nxt;
  logic [DATA_W-1:0]   req_pc;
  logic                discard;
  logic                discard_nxt;
  logic                skid_vld;
  logic                skid_vld_nxt;
  logic [DATA_W-1:0]   skid_pc;
  logic [DATA_W-1:0]   skid_instr;
  logic                ifid_valid_nxt;
  logic                ifid_ld;
  logic                ifid_from_skid;
  logic                skid_ld;
  logic                req_ld;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
    word_align = {addr[DATA_W-1:2], 2'b00};
  endfunction

  // Request side depends on registered state only, never on stall/takebranch.
  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;

  // Next-state and load decisions; a redirect wins over everything, including stall.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    discard_nxt    = discard;
    skid_vld_nxt   = skid_vld;
    ifid_valid_nxt = stall ? ifid_valid : 1'b0;
    ifid_ld        = 1'b0;
    ifid_from_skid = 1'b0;
    skid_ld        = 1'b0;
    req_ld         = 1'b0;

    if (takebranch) begin
      pc_nxt         = word_align(JalAddr);
      ifid_valid_nxt = 1'b0;
      skid_vld_nxt   = 1'b0;
    end

    case (state)
      ST_FETCH: begin
        if (takebranch) begin
          // A grant in the redirect cycle belongs to the old path: mark it stale.
          if (imem_gnt) begin
            discard_nxt = 1'b1;
            state_nxt   = ST_WAIT;
          end
        end else if (imem_gnt) begin
          req_ld    = 1'b1;
          pc_nxt    = pc + 32'd4;
          state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (takebranch) begin
          if (imem_rvalid) begin
            discard_nxt = 1'b0;
            state_nxt   = ST_FETCH;
          end else begin
            discard_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (discard) begin
            discard_nxt = 1'b0;
            state_nxt   = ST_FETCH;
          end else if (!stall) begin
            ifid_ld        = 1'b1;
            ifid_valid_nxt = 1'b1;
            state_nxt      = ST_FETCH;
          end else begin
            skid_ld      = 1'b1;
            skid_vld_nxt = 1'b1;
            state_nxt    = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (takebranch) begin
          state_nxt = ST_FETCH;
        end else if (!stall && skid_vld) begin
          ifid_ld        = 1'b1;
          ifid_from_skid = 1'b1;
          ifid_valid_nxt = 1'b1;
          skid_vld_nxt   = 1'b0;
          state_nxt      = ST_FETCH;
        end
      end

      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

  // Control state and the architecturally visible IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      discard    <= 1'b0;
      skid_vld   <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      discard    <= discard_nxt;
      skid_vld   <= skid_vld_nxt;
      ifid_valid <= ifid_valid_nxt;
      if (ifid_ld) begin
        ifid_pc    <= ifid_from_skid ? skid_pc    : req_pc;
        ifid_instr <= ifid_from_skid ? skid_instr : imem_rdata;
      end
    end
  end

  // Outstanding-request PC and skid payload; qualified by state/skid_vld, so no reset.
  always_ff @(posedge clk) begin
    if (req_ld) begin
      req_pc <= pc;
    end
    if (skid_ld) begin
      skid_pc    <= req_pc;
      skid_instr <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: streaming fetch, stall/skid, redirects in
// every state, PC wrap-around and reset in the middle of a transaction.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        takebranch;
  logic [31:0] JalAddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  int tests_run;
  int tests_failed;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .takebranch (takebranch),
    .JalAddr    (JalAddr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .ifid_valid (ifid_valid),
    .ifid_pc    (ifid_pc),
    .ifid_instr (ifid_instr)
  );

  always #5 clk = ~clk;

  // Memory contents: instruction word is the address xor a fixed tag.
  function automatic logic [31:0] word(input logic [31:0] a);
    word = a ^ 32'h5A5A_0000;
  endfunction

  // One clock: zero-wait memory answers a grant on the following cycle.
  task automatic cycle();
    logic        fire;
    logic [31:0] a;
    fire = imem_req && imem_gnt;
    a    = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = fire;
    imem_rdata  = fire ? word(a) : 32'h0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b0, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_ifid: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr}, {1'b0, 32'h0, 32'h0});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    tests_run++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_req: got %h expected %h", {imem_req, imem_addr}, {1'b1, 32'h0});
    end
    rst_n    = 1'b1;
    imem_gnt = 1'b1;
  endtask

  task automatic test_stream();
    cycle();
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_wait_noreq: got %b expected 0", imem_req);
    end
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr} !== {1'b1, 32'h0, 32'h5A5A_0000, 1'b1, 32'h4}) begin
      tests_failed++;
      $display("FAIL stream_pc0: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr}, {1'b1, 32'h0, 32'h5A5A_0000, 1'b1, 32'h4});
    end
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b0, 32'h0, 32'h5A5A_0000}) begin
      tests_failed++;
      $display("FAIL stream_bubble: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr}, {1'b0, 32'h0, 32'h5A5A_0000});
    end
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr} !== {1'b1, 32'h4, 32'h5A5A_0004, 1'b1, 32'h8}) begin
      tests_failed++;
      $display("FAIL stream_pc4: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr}, {1'b1, 32'h4, 32'h5A5A_0004, 1'b1, 32'h8});
    end
  endtask

  task automatic test_stall();
    cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if ({imem_req, ifid_valid, ifid_pc, ifid_instr} !== {1'b0, 1'b0, 32'h4, 32'h5A5A_0004}) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: got %h expected %h", i, {imem_req, ifid_valid, ifid_pc, ifid_instr}, {1'b0, 1'b0, 32'h4, 32'h5A5A_0004});
      end
    end
    stall = 1'b0;
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr} !== {1'b1, 32'h8, 32'h5A5A_0008, 1'b1, 32'hC}) begin
      tests_failed++;
      $display("FAIL stall_release: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr}, {1'b1, 32'h8, 32'h5A5A_0008, 1'b1, 32'hC});
    end
  endtask

  task automatic test_redirect_wait();
    cycle();
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr, imem_addr} !== {1'b1, 32'hC, 32'h5A5A_000C, 32'h10}) begin
      tests_failed++;
      $display("FAIL redir_wait_pre: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr, imem_addr}, {1'b1, 32'hC, 32'h5A5A_000C, 32'h10});
    end
    cycle();
    imem_rvalid = 1'b0;
    takebranch  = 1'b1;
    JalAddr     = 32'h0000_0102;
    cycle();
    tests_run++;
    if ({ifid_valid, imem_req} !== 2'b00) begin
      tests_failed++;
      $display("FAIL redir_wait_bubble: got %b expected 00", {ifid_valid, imem_req});
    end
    takebranch  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word(32'h10);
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, imem_req, imem_addr} !== {1'b0, 32'hC, 1'b1, 32'h100}) begin
      tests_failed++;
      $display("FAIL redir_wait_drop: got %h expected %h", {ifid_valid, ifid_pc, imem_req, imem_addr}, {1'b0, 32'hC, 1'b1, 32'h100});
    end
    cycle();
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'h100, 32'h5A5A_0100}) begin
      tests_failed++;
      $display("FAIL redir_wait_target: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr}, {1'b1, 32'h100, 32'h5A5A_0100});
    end
  endtask

  task automatic test_redirect_fetch();
    imem_gnt   = 1'b0;
    takebranch = 1'b1;
    JalAddr    = 32'h20;
    cycle();
    tests_run++;
    if ({ifid_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h20}) begin
      tests_failed++;
      $display("FAIL redir_fetch_nognt: got %h expected %h", {ifid_valid, imem_req, imem_addr}, {1'b0, 1'b1, 32'h20});
    end
    JalAddr  = 32'h40;
    imem_gnt = 1'b1;
    cycle();
    takebranch = 1'b0;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_fetch_gnt_wait: got %b expected 0", imem_req);
    end
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, imem_req, imem_addr} !== {1'b0, 32'h100, 1'b1, 32'h40}) begin
      tests_failed++;
      $display("FAIL redir_fetch_gnt_drop: got %h expected %h", {ifid_valid, ifid_pc, imem_req, imem_addr}, {1'b0, 32'h100, 1'b1, 32'h40});
    end
    cycle();
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr, imem_addr} !== {1'b1, 32'h40, 32'h5A5A_0040, 32'h44}) begin
      tests_failed++;
      $display("FAIL redir_fetch_target: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr, imem_addr}, {1'b1, 32'h40, 32'h5A5A_0040, 32'h44});
    end
  endtask

  task automatic test_redirect_rvalid();
    cycle();
    takebranch = 1'b1;
    JalAddr    = 32'h80;
    cycle();
    takebranch = 1'b0;
    tests_run++;
    if ({ifid_valid, ifid_pc, imem_req, imem_addr} !== {1'b0, 32'h40, 1'b1, 32'h80}) begin
      tests_failed++;
      $display("FAIL redir_rvalid: got %h expected %h", {ifid_valid, ifid_pc, imem_req, imem_addr}, {1'b0, 32'h40, 1'b1, 32'h80});
    end
  endtask

  task automatic test_redirect_hold();
    cycle();
    stall = 1'b1;
    cycle();
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_hold_noreq: got %b expected 0", imem_req);
    end
    takebranch = 1'b1;
    JalAddr    = 32'h200;
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, imem_req, imem_addr} !== {1'b0, 32'h40, 1'b1, 32'h200}) begin
      tests_failed++;
      $display("FAIL redir_hold: got %h expected %h", {ifid_valid, ifid_pc, imem_req, imem_addr}, {1'b0, 32'h40, 1'b1, 32'h200});
    end
    takebranch = 1'b0;
    stall      = 1'b0;
    cycle();
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'h200, 32'h5A5A_0200}) begin
      tests_failed++;
      $display("FAIL redir_hold_target: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr}, {1'b1, 32'h200, 32'h5A5A_0200});
    end
  endtask

  task automatic test_wrap();
    imem_gnt   = 1'b0;
    takebranch = 1'b1;
    JalAddr    = 32'hFFFF_FFFF;
    cycle();
    tests_run++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      tests_failed++;
      $display("FAIL wrap_align: got %h expected %h", {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFFC});
    end
    takebranch = 1'b0;
    imem_gnt   = 1'b1;
    cycle();
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'hA5A5_FFFC, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL wrap_next: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr}, {1'b1, 32'hFFFF_FFFC, 32'hA5A5_FFFC, 1'b1, 32'h0});
    end
  endtask

  task automatic test_reset_midflight();
    cycle();
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    rst_n       = 1'b0;
    #1;
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr} !== {1'b0, 32'h0, 32'h0, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL midreset_async: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr}, {1'b0, 32'h0, 32'h0, 1'b1, 32'h0});
    end
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr} !== {1'b0, 32'h0, 32'h0, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL midreset_stale: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr}, {1'b0, 32'h0, 32'h0, 1'b1, 32'h0});
    end
    imem_gnt = 1'b1;
    cycle();
    tests_run++;
    if ({ifid_valid, imem_req} !== 2'b00) begin
      tests_failed++;
      $display("FAIL midreset_wait: got %b expected 00", {ifid_valid, imem_req});
    end
    cycle();
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'h0, 32'h5A5A_0000}) begin
      tests_failed++;
      $display("FAIL midreset_first: got %h expected %h", {ifid_valid, ifid_pc, ifid_instr}, {1'b1, 32'h0, 32'h5A5A_0000});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b1;
    stall        = 1'b0;
    takebranch   = 1'b0;
    JalAddr      = 32'h0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    tests_run    = 0;
    tests_failed = 0;

    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_fetch();
    test_redirect_rvalid();
    test_redirect_hold();
    test_wrap();
    test_reset_midflight();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
